pipeline_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the PC and IF/ID write enables and the IF/ID and ID/EX flush controls. It reacts to four conditions: load-use hazards between ID and EX, taken branches or jumps resolved in EX, multi-cycle fetch-redirect penalties, and external memory-wait holds. It sits beside the fetch/decode stages and replaces the ad-hoc tie-offs of `PC_write`, `IF_ID_write` and `PCSrc` gating.

---
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: hazard and sequencing controller for the five-stage
// RISC-V pipeline. It drives the PC and IF/ID enables and the IF/ID and ID/EX
// flushes from load-use hazards, EX-resolved redirects and memory-wait holds.
// Optional statistics counters are built only when PIPELINE_HAZARD_STATS_EN
// is defined; otherwise the three counter outputs are tied to zero.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_DEPTH = 1,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_req,
    input  logic              PCSrc,
    input  logic              MemRead_EX,
    input  logic [4:0]        RD_EX,
    input  logic [4:0]        RS1_ID,
    input  logic [4:0]        RS2_ID,
    input  logic [6:0]        OPCODE_ID,
    output logic              PC_write,
    output logic              IF_ID_write,
    output logic              IF_ID_flush,
    output logic              ID_EX_flush,
    output logic              pipe_hold,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] flush_cycles,
    output logic [STAT_W-1:0] hold_cycles
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Flush cycles still owed after the PCSrc cycle itself.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_DEPTH - 1);

    logic [0:0] state;
    logic [0:0] next_state;
    logic [3:0] flush_left;
    logic [3:0] next_flush_left;
    logic       rs1_used;
    logic       rs2_used;
    logic       lu;
    logic       stall_now;

    // Decode which source registers the ID instruction really reads, and the load-use hazard.
    always_comb begin
        rs1_used = !((OPCODE_ID == OP_LUI) || (OPCODE_ID == OP_AUIPC) || (OPCODE_ID == OP_JAL));
        rs2_used = (OPCODE_ID == OP_RTYPE) || (OPCODE_ID == OP_STORE) || (OPCODE_ID == OP_BRANCH);
        lu = MemRead_EX && (RD_EX != 5'd0) &&
             ((rs1_used && (RS1_ID == RD_EX)) || (rs2_used && (RS2_ID == RD_EX)));
    end

    // Prioritised output decode and next-state selection: reset, hold, redirect, flush, stall.
    always_comb begin
        PC_write        = 1'b1;
        IF_ID_write     = 1'b1;
        IF_ID_flush     = 1'b0;
        ID_EX_flush     = 1'b0;
        pipe_hold       = 1'b0;
        stall_now       = 1'b0;
        next_state      = state;
        next_flush_left = flush_left;
        if (reset) begin
            next_state      = RUN;
            next_flush_left = 4'd0;
        end else if (hold_req) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
        end else if (PCSrc) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
            if (FLUSH_DEPTH > 1) begin
                next_state      = FLUSH;
                next_flush_left = FLUSH_INIT;
            end else begin
                next_state      = RUN;
                next_flush_left = 4'd0;
            end
        end else if (state == FLUSH) begin
            IF_ID_flush     = 1'b1;
            ID_EX_flush     = 1'b1;
            next_flush_left = flush_left - 4'd1;
            if (flush_left == 4'd1) begin
                next_state = RUN;
            end
        end else if (lu) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
            stall_now   = 1'b1;
        end
    end

    // Register the controller state and the remaining flush count.
    always_ff @(posedge clk) begin
        state      <= next_state;
        flush_left <= next_flush_left;
    end

`ifdef PIPELINE_HAZARD_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    // Saturating statistics counters for stalls, flushed cycles and holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
            hold_cycles  <= '0;
        end else begin
            if (stall_now && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STAT_ONE;
            end
            if (IF_ID_flush && (flush_cycles != '1)) begin
                flush_cycles <= flush_cycles + STAT_ONE;
            end
            if (hold_req && (hold_cycles != '1)) begin
                hold_cycles <= hold_cycles + STAT_ONE;
            end
        end
    end
`else
    assign stall_cycles = '0;
    assign flush_cycles = '0;
    assign hold_cycles  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: self-checking bench for pipeline_hazard_ctrl with
// FLUSH_DEPTH=3 and STAT_W=4. Expected counter values follow
// PIPELINE_HAZARD_STATS_EN when it is defined for the build.
module tb_pipeline_hazard_ctrl;

    localparam int DEPTH  = 3;
    localparam int SW     = 4;
    localparam int SATMAX = (1 << SW) - 1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hold_req = 1'b0;
    logic          PCSrc = 1'b0;
    logic          MemRead_EX = 1'b0;
    logic [4:0]    RD_EX = 5'd0;
    logic [4:0]    RS1_ID = 5'd0;
    logic [4:0]    RS2_ID = 5'd0;
    logic [6:0]    OPCODE_ID = OP_IMM;
    logic          PC_write;
    logic          IF_ID_write;
    logic          IF_ID_flush;
    logic          ID_EX_flush;
    logic          pipe_hold;
    logic [SW-1:0] stall_cycles;
    logic [SW-1:0] flush_cycles;
    logic [SW-1:0] hold_cycles;

    int checks = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.FLUSH_DEPTH(DEPTH), .STAT_W(SW)) dut (
        .clk(clk), .reset(reset), .hold_req(hold_req), .PCSrc(PCSrc),
        .MemRead_EX(MemRead_EX), .RD_EX(RD_EX), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
        .OPCODE_ID(OPCODE_ID), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
        .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush), .pipe_hold(pipe_hold),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles), .hold_cycles(hold_cycles)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Spec-level load-use test: which sources an opcode reads, then a register match.
    function automatic bit model_lu(bit mr, logic [4:0] rd, logic [4:0] rs1,
                                    logic [4:0] rs2, logic [6:0] op);
        bit uses1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
        bit uses2 = (op == OP_RTYPE || op == OP_STORE || op == OP_BRANCH);
        return mr && (rd != 5'd0) && ((uses1 && rs1 == rd) || (uses2 && rs2 == rd));
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit hold, input bit pcsrc, input bit mr,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [6:0] op);
        @(posedge clk);
        #1;
        reset      = rst;
        hold_req   = hold;
        PCSrc      = pcsrc;
        MemRead_EX = mr;
        RD_EX      = rd;
        RS1_ID     = rs1;
        RS2_ID     = rs2;
        OPCODE_ID  = op;
        #2;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, OP_IMM);
    endtask

    // Reference model: number of flushed cycles still owed after the current one, plus counters.
    int owed = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_hold = 0;

    // Every cycle: compare DUT outputs with the model, then advance the model to the next edge.
    initial begin
        bit e_pcw, e_ifw, e_iff, e_idf, e_hold, stall;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_pcw = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0; stall = 0;
            if (!reset) begin
                if (hold_req) begin
                    e_pcw = 0; e_ifw = 0; e_hold = 1;
                end else if (PCSrc || owed > 0) begin
                    e_iff = 1; e_idf = 1;
                end else if (model_lu(MemRead_EX, RD_EX, RS1_ID, RS2_ID, OPCODE_ID)) begin
                    e_pcw = 0; e_ifw = 0; e_idf = 1; stall = 1;
                end
            end
            checkOutput("ctrl{pcw,ifw,iff,idf,hold}",
                        int'({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold}),
                        int'({e_pcw, e_ifw, e_iff, e_idf, e_hold}));
`ifdef PIPELINE_HAZARD_STATS_EN
            checkOutput("stall_cycles", int'(stall_cycles), m_stall);
            checkOutput("flush_cycles", int'(flush_cycles), m_flush);
            checkOutput("hold_cycles", int'(hold_cycles), m_hold);
`else
            checkOutput("stall_cycles", int'(stall_cycles), 0);
            checkOutput("flush_cycles", int'(flush_cycles), 0);
            checkOutput("hold_cycles", int'(hold_cycles), 0);
`endif
            if (reset) begin
                owed = 0; m_stall = 0; m_flush = 0; m_hold = 0;
            end else begin
                if (hold_req) begin
                    m_hold = (m_hold < SATMAX) ? m_hold + 1 : SATMAX;
                end else if (PCSrc) begin
                    owed = DEPTH - 1;
                end else if (owed > 0) begin
                    owed = owed - 1;
                end
                if (e_iff) m_flush = (m_flush < SATMAX) ? m_flush + 1 : SATMAX;
                if (stall) m_stall = (m_stall < SATMAX) ? m_stall + 1 : SATMAX;
            end
        end
    end

    // Directed scenarios with hand-computed expectations, then randomized traffic.
    initial begin
        logic [6:0] ops [9];
        ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_RTYPE, OP_STORE, OP_BRANCH, OP_LOAD, OP_IMM, OP_JALR};

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, OP_IMM);
        checkOutput("reset PC_write", int'(PC_write), 1);
        checkOutput("reset IF_ID_flush", int'(IF_ID_flush), 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, OP_RTYPE);
        checkOutput("reset ignores inputs", int'({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold}), 5'b11000);
        idleCycle();

        // Load-use on rs2 of an R-type: one bubble, then bubble in EX clears it.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5, OP_RTYPE);
        checkOutput("lu PC_write", int'(PC_write), 0);
        checkOutput("lu IF_ID_write", int'(IF_ID_write), 0);
        checkOutput("lu ID_EX_flush", int'(ID_EX_flush), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd5, OP_RTYPE);
        checkOutput("lu released PC_write", int'(PC_write), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, OP_RTYPE);
        checkOutput("lu rd=x0 no stall", int'(PC_write), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, OP_LUI);
        checkOutput("lu LUI no stall", int'(PC_write), 1);

        // Redirect pulse: three flushed cycles, then back to RUN.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, OP_IMM);
        checkOutput("redirect c1 flush", int'(IF_ID_flush), 1);
        idleCycle();
        checkOutput("redirect c2 flush", int'(IF_ID_flush), 1);
        idleCycle();
        checkOutput("redirect c3 flush", int'(IF_ID_flush), 1);
        idleCycle();
        checkOutput("redirect c4 clear", int'(IF_ID_flush), 0);

        // Second redirect in cycle 2 extends the flush through cycle 4.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, OP_IMM);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, OP_IMM);
        idleCycle();
        idleCycle();
        checkOutput("re-redirect c4 flush", int'(IF_ID_flush), 1);
        idleCycle();
        checkOutput("re-redirect c5 clear", int'(IF_ID_flush), 0);

        // Load-use conditions during FLUSH are ignored.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, OP_IMM);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0, OP_IMM);
        checkOutput("lu in FLUSH PC_write", int'(PC_write), 1);
        checkOutput("lu in FLUSH flush", int'(IF_ID_flush), 1);
        idleCycle();
        idleCycle();

        // Hold beats redirect and load-use; redirect executes on release.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, OP_RTYPE);
            checkOutput("hold ctrl", int'({PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold}), 5'b00001);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, OP_RTYPE);
        checkOutput("hold release redirect", int'({PC_write, IF_ID_flush, pipe_hold}), 3'b110);
        idleCycle();
        idleCycle();
        idleCycle();

        // Reset in flush cycle 2 leaves no residual flush.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, OP_IMM);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, OP_IMM);
        idleCycle();
        checkOutput("after mid-flush reset", int'({PC_write, IF_ID_flush, ID_EX_flush}), 3'b100);

        // Twenty stall cycles saturate the 4-bit stall counter.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, OP_LOAD);
        end
        idleCycle();
`ifdef PIPELINE_HAZARD_STATS_EN
        checkOutput("stall_cycles saturated", int'(stall_cycles), 15);
`else
        checkOutput("stall_cycles tied off", int'(stall_cycles), 0);
`endif

        // Randomized traffic; small register range makes hazards frequent.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 6) == 0),
                          ($urandom_range(0, 6) == 0), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]);
        end
        idleCycle();
        idleCycle();
        @(posedge clk);
        #6;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
